ex_skid_reg: RTL and testbench

EX_SKID_REG -- requirements
Module: ex_skid_reg

---
 rtl/ex_skid_reg_pkg.sv | 44 ++++
 rtl/ex_skid_reg_beat_fmt.sv | 59 +++++
 rtl/ex_skid_reg.sv | 213 +++++++++++++++++++++
 tb/tb_ex_skid_reg.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_skid_reg_pkg.sv
// Shared ISA codes, beat field layout and FSM state type for the EX-stage
// skid register.
//   MEM_OP_* / CTRL_OP_* / ISA_EXP_* : opcode and exception encodings
//   beat_ctrl_t                      : fixed-width control fields of one beat
//   skid_state_e                     : buffer occupancy state
package ex_skid_reg_pkg;

  localparam int unsigned MEM_OP_W   = 2;
  localparam int unsigned CTRL_OP_W  = 2;
  localparam int unsigned EXP_CODE_W = 3;

  localparam logic [MEM_OP_W-1:0]   MEM_OP_NOP       = MEM_OP_W'(0);
  localparam logic [CTRL_OP_W-1:0]  CTRL_OP_NOP      = CTRL_OP_W'(0);
  localparam logic [EXP_CODE_W-1:0] ISA_EXP_NO_EXP   = EXP_CODE_W'(0);
  localparam logic [EXP_CODE_W-1:0] ISA_EXP_EXT_INT  = EXP_CODE_W'(1);
  localparam logic [EXP_CODE_W-1:0] ISA_EXP_OVERFLOW = EXP_CODE_W'(3);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

  // Control part of a beat; wide parameterised fields are carried separately.
  typedef struct packed {
    logic                  br_flag;
    logic [MEM_OP_W-1:0]   mem_op;
    logic [CTRL_OP_W-1:0]  ctrl_op;
    logic                  gpr_we_;
    logic [EXP_CODE_W-1:0] exp_code;
  } beat_ctrl_t;

  // Control fields of an empty entry: no write-back, no exception.
  function automatic beat_ctrl_t beat_ctrl_idle();
    beat_ctrl_t c;
    c.br_flag  = 1'b0;
    c.mem_op   = MEM_OP_NOP;
    c.ctrl_op  = CTRL_OP_NOP;
    c.gpr_we_  = 1'b1;
    c.exp_code = ISA_EXP_NO_EXP;
    return c;
  endfunction

endpackage

// File: rtl/ex_skid_reg_beat_fmt.sv
// ex_beat_fmt: combinational capture/rewrite of one incoming beat.
// Ports:
//   i_int_detect, i_alu_of : exception sources (interrupt wins)
//   i_alu_out, i_pc, i_*   : raw ID/ALU beat fields
//   o_*_c                  : formatted beat, ready to be stored in any entry
module ex_beat_fmt
  import ex_skid_reg_pkg::*;
#(
  parameter int unsigned PC_W       = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_int_detect,
  input  logic                  i_alu_of,
  input  logic [DATA_W-1:0]     i_alu_out,
  input  logic [PC_W-1:0]       i_pc,
  input  logic                  i_br_flag,
  input  logic [MEM_OP_W-1:0]   i_mem_op,
  input  logic [DATA_W-1:0]     i_mem_wr_data,
  input  logic [CTRL_OP_W-1:0]  i_ctrl_op,
  input  logic [REG_ADDR_W-1:0] i_dst_addr,
  input  logic                  i_gpr_we_,
  input  logic [EXP_CODE_W-1:0] i_exp_code,
  output logic [PC_W-1:0]       o_pc_c,
  output logic                  o_br_flag_c,
  output logic [MEM_OP_W-1:0]   o_mem_op_c,
  output logic [DATA_W-1:0]     o_mem_wr_data_c,
  output logic [CTRL_OP_W-1:0]  o_ctrl_op_c,
  output logic [REG_ADDR_W-1:0] o_dst_addr_c,
  output logic                  o_gpr_we_c_,
  output logic [EXP_CODE_W-1:0] o_exp_code_c,
  output logic [DATA_W-1:0]     o_out_c
);

  // PC and branch-delay flag survive an exception so the handler can return.
  assign o_pc_c      = i_pc;
  assign o_br_flag_c = i_br_flag;

  // Exceptions squash every side effect of the beat and tag its cause.
  always_comb begin
    o_mem_op_c      = i_mem_op;
    o_mem_wr_data_c = i_mem_wr_data;
    o_ctrl_op_c     = i_ctrl_op;
    o_dst_addr_c    = i_dst_addr;
    o_gpr_we_c_     = i_gpr_we_;
    o_exp_code_c    = i_exp_code;
    o_out_c         = i_alu_out;
    if (i_int_detect || i_alu_of) begin
      o_mem_op_c      = MEM_OP_NOP;
      o_mem_wr_data_c = '0;
      o_ctrl_op_c     = CTRL_OP_NOP;
      o_dst_addr_c    = '0;
      o_gpr_we_c_     = 1'b1;
      o_out_c         = '0;
      o_exp_code_c    = i_int_detect ? ISA_EXP_EXT_INT : ISA_EXP_OVERFLOW;
    end
  end

endmodule

// File: rtl/ex_skid_reg.sv
// ex_skid_reg: EX pipeline register with optional two-entry skid buffer.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   in_valid / in_ready        : upstream handshake
//   flush, int_detect, alu_of  : flush and exception inputs
//   alu_out, id_*              : incoming beat fields
//   ex_en / out_ready          : downstream handshake
//   ex_*                       : registered outgoing beat fields
// SKID_EN=1 gives a registered in_ready (main + skid entry);
// SKID_EN=0 gives a single register with combinational in_ready.
module ex_skid_reg
  import ex_skid_reg_pkg::*;
#(
  parameter int unsigned PC_W       = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned SKID_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  int_detect,
  input  logic                  alu_of,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic [PC_W-1:0]       id_pc,
  input  logic                  id_br_flag,
  input  logic [1:0]            id_mem_op,
  input  logic [DATA_W-1:0]     id_mem_wr_data,
  input  logic [1:0]            id_ctrl_op,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_gpr_we_,
  input  logic [2:0]            id_exp_code,
  output logic                  ex_en,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       ex_pc,
  output logic                  ex_br_flag,
  output logic [1:0]            ex_mem_op,
  output logic [DATA_W-1:0]     ex_mem_wr_data,
  output logic [1:0]            ex_ctrl_op,
  output logic [REG_ADDR_W-1:0] ex_dst_addr,
  output logic                  ex_gpr_we_,
  output logic [2:0]            ex_exp_code,
  output logic [DATA_W-1:0]     ex_out
);

  localparam bit LP_SKID = (SKID_EN != 0);

  skid_state_e           r_state;
  logic                  r_in_ready;

  logic                  r_main_vld;
  logic [PC_W-1:0]       r_main_pc;
  beat_ctrl_t            r_main_ctrl;
  logic [DATA_W-1:0]     r_main_wr_data;
  logic [REG_ADDR_W-1:0] r_main_dst;
  logic [DATA_W-1:0]     r_main_out;

  logic [PC_W-1:0]       r_skid_pc;
  beat_ctrl_t            r_skid_ctrl;
  logic [DATA_W-1:0]     r_skid_wr_data;
  logic [REG_ADDR_W-1:0] r_skid_dst;
  logic [DATA_W-1:0]     r_skid_out;

  logic                  w_accept;
  logic [PC_W-1:0]       w_fmt_pc;
  logic                  w_fmt_br_flag;
  logic [1:0]            w_fmt_mem_op;
  logic [DATA_W-1:0]     w_fmt_wr_data;
  logic [1:0]            w_fmt_ctrl_op;
  logic [REG_ADDR_W-1:0] w_fmt_dst;
  logic                  w_fmt_gpr_we_;
  logic [2:0]            w_fmt_exp_code;
  logic [DATA_W-1:0]     w_fmt_out;
  beat_ctrl_t            w_fmt_ctrl;

  // One formatter feeds whichever entry captures the beat.
  ex_beat_fmt #(
    .PC_W       (PC_W),
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_beat_fmt (
    .i_int_detect    (int_detect),
    .i_alu_of        (alu_of),
    .i_alu_out       (alu_out),
    .i_pc            (id_pc),
    .i_br_flag       (id_br_flag),
    .i_mem_op        (id_mem_op),
    .i_mem_wr_data   (id_mem_wr_data),
    .i_ctrl_op       (id_ctrl_op),
    .i_dst_addr      (id_dst_addr),
    .i_gpr_we_       (id_gpr_we_),
    .i_exp_code      (id_exp_code),
    .o_pc_c          (w_fmt_pc),
    .o_br_flag_c     (w_fmt_br_flag),
    .o_mem_op_c      (w_fmt_mem_op),
    .o_mem_wr_data_c (w_fmt_wr_data),
    .o_ctrl_op_c     (w_fmt_ctrl_op),
    .o_dst_addr_c    (w_fmt_dst),
    .o_gpr_we_c_     (w_fmt_gpr_we_),
    .o_exp_code_c    (w_fmt_exp_code),
    .o_out_c         (w_fmt_out)
  );

  assign w_fmt_ctrl.br_flag  = w_fmt_br_flag;
  assign w_fmt_ctrl.mem_op   = w_fmt_mem_op;
  assign w_fmt_ctrl.ctrl_op  = w_fmt_ctrl_op;
  assign w_fmt_ctrl.gpr_we_  = w_fmt_gpr_we_;
  assign w_fmt_ctrl.exp_code = w_fmt_exp_code;

  // Skid mode: ready comes from a flop tracking (state != SKID), so there is
  // no combinational path from out_ready back upstream.
  assign in_ready = LP_SKID ? r_in_ready : (out_ready | ~r_main_vld);
  assign w_accept = in_valid & in_ready;

  // Occupancy FSM and entry storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_EMPTY;
      r_in_ready     <= 1'b1;
      r_main_vld     <= 1'b0;
      r_main_pc      <= '0;
      r_main_ctrl    <= beat_ctrl_idle();
      r_main_wr_data <= '0;
      r_main_dst     <= '0;
      r_main_out     <= '0;
      r_skid_pc      <= '0;
      r_skid_ctrl    <= beat_ctrl_idle();
      r_skid_wr_data <= '0;
      r_skid_dst     <= '0;
      r_skid_out     <= '0;
    end else if (flush) begin
      // Flush overrides any same-cycle accept or output transfer.
      r_state        <= ST_EMPTY;
      r_in_ready     <= 1'b1;
      r_main_vld     <= 1'b0;
      r_main_pc      <= '0;
      r_main_ctrl    <= beat_ctrl_idle();
      r_main_wr_data <= '0;
      r_main_dst     <= '0;
      r_main_out     <= '0;
      r_skid_pc      <= '0;
      r_skid_ctrl    <= beat_ctrl_idle();
      r_skid_wr_data <= '0;
      r_skid_dst     <= '0;
      r_skid_out     <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_vld     <= 1'b1;
            r_main_pc      <= w_fmt_pc;
            r_main_ctrl    <= w_fmt_ctrl;
            r_main_wr_data <= w_fmt_wr_data;
            r_main_dst     <= w_fmt_dst;
            r_main_out     <= w_fmt_out;
            r_state        <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_accept && out_ready) begin
            // Outgoing beat leaves while the new one takes its place.
            r_main_pc      <= w_fmt_pc;
            r_main_ctrl    <= w_fmt_ctrl;
            r_main_wr_data <= w_fmt_wr_data;
            r_main_dst     <= w_fmt_dst;
            r_main_out     <= w_fmt_out;
          end else if (w_accept && LP_SKID) begin
            r_skid_pc      <= w_fmt_pc;
            r_skid_ctrl    <= w_fmt_ctrl;
            r_skid_wr_data <= w_fmt_wr_data;
            r_skid_dst     <= w_fmt_dst;
            r_skid_out     <= w_fmt_out;
            r_state        <= ST_SKID;
            r_in_ready     <= 1'b0;
          end else if (out_ready) begin
            r_main_vld     <= 1'b0;
            r_state        <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            r_main_pc      <= r_skid_pc;
            r_main_ctrl    <= r_skid_ctrl;
            r_main_wr_data <= r_skid_wr_data;
            r_main_dst     <= r_skid_dst;
            r_main_out     <= r_skid_out;
            r_state        <= ST_FULL;
            r_in_ready     <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_main_vld <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ex_en          = r_main_vld;
  assign ex_pc          = r_main_pc;
  assign ex_br_flag     = r_main_ctrl.br_flag;
  assign ex_mem_op      = r_main_ctrl.mem_op;
  assign ex_mem_wr_data = r_main_wr_data;
  assign ex_ctrl_op     = r_main_ctrl.ctrl_op;
  assign ex_dst_addr    = r_main_dst;
  assign ex_gpr_we_     = r_main_ctrl.gpr_we_;
  assign ex_exp_code    = r_main_ctrl.exp_code;
  assign ex_out         = r_main_out;

endmodule

// File: tb/tb_ex_skid_reg.sv
// Self-checking bench for ex_skid_reg: one instance in skid mode (SKID_EN=1)
// and one in single-register mode (SKID_EN=0), driven by the same inputs and
// each checked against a queue model of its buffered beats.
module tb_ex_skid_reg;

  typedef struct packed {
    logic [29:0] pc;
    logic        br;
    logic [1:0]  mem_op;
    logic [31:0] wd;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst;
    logic        we_;
    logic [2:0]  exp;
    logic [31:0] out;
  } beat_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, flush, int_detect, alu_of, out_ready;
  logic [31:0] alu_out, id_mem_wr_data;
  logic [29:0] id_pc;
  logic        id_br_flag, id_gpr_we_;
  logic [1:0]  id_mem_op, id_ctrl_op;
  logic [4:0]  id_dst_addr;
  logic [2:0]  id_exp_code;

  logic [1:0]  in_ready, ex_en, ex_br_flag, ex_gpr_we_;
  logic [29:0] ex_pc          [2];
  logic [1:0]  ex_mem_op      [2];
  logic [31:0] ex_mem_wr_data [2];
  logic [1:0]  ex_ctrl_op     [2];
  logic [4:0]  ex_dst_addr    [2];
  logic [2:0]  ex_exp_code    [2];
  logic [31:0] ex_out         [2];

  int total = 0;
  int bad   = 0;
  beat_t q0[$];
  beat_t q1[$];
  int acc_obs [2];
  int xfer_obs[2];

  ex_skid_reg #(.PC_W(30), .DATA_W(32), .REG_ADDR_W(5), .SKID_EN(1)) u_dut_skid (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .flush(flush), .int_detect(int_detect), .alu_of(alu_of), .alu_out(alu_out),
    .id_pc(id_pc), .id_br_flag(id_br_flag), .id_mem_op(id_mem_op),
    .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr),
    .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code), .ex_en(ex_en[0]),
    .out_ready(out_ready), .ex_pc(ex_pc[0]), .ex_br_flag(ex_br_flag[0]),
    .ex_mem_op(ex_mem_op[0]), .ex_mem_wr_data(ex_mem_wr_data[0]),
    .ex_ctrl_op(ex_ctrl_op[0]), .ex_dst_addr(ex_dst_addr[0]),
    .ex_gpr_we_(ex_gpr_we_[0]), .ex_exp_code(ex_exp_code[0]), .ex_out(ex_out[0])
  );

  ex_skid_reg #(.PC_W(30), .DATA_W(32), .REG_ADDR_W(5), .SKID_EN(0)) u_dut_single (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .flush(flush), .int_detect(int_detect), .alu_of(alu_of), .alu_out(alu_out),
    .id_pc(id_pc), .id_br_flag(id_br_flag), .id_mem_op(id_mem_op),
    .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr),
    .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code), .ex_en(ex_en[1]),
    .out_ready(out_ready), .ex_pc(ex_pc[1]), .ex_br_flag(ex_br_flag[1]),
    .ex_mem_op(ex_mem_op[1]), .ex_mem_wr_data(ex_mem_wr_data[1]),
    .ex_ctrl_op(ex_ctrl_op[1]), .ex_dst_addr(ex_dst_addr[1]),
    .ex_gpr_we_(ex_gpr_we_[1]), .ex_exp_code(ex_exp_code[1]), .ex_out(ex_out[1])
  );

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic beat_t obs(input int k);
    beat_t b;
    b.pc = ex_pc[k]; b.br = ex_br_flag[k]; b.mem_op = ex_mem_op[k];
    b.wd = ex_mem_wr_data[k]; b.ctrl_op = ex_ctrl_op[k]; b.dst = ex_dst_addr[k];
    b.we_ = ex_gpr_we_[k]; b.exp = ex_exp_code[k]; b.out = ex_out[k];
    return b;
  endfunction

  function automatic beat_t rst_beat();
    beat_t b = '0;
    b.we_ = 1'b1;
    return b;
  endfunction

  // What a beat looks like once stored, straight from the rewrite rules.
  function automatic beat_t fmt_model();
    beat_t b;
    b.pc = id_pc;
    b.br = id_br_flag;
    if (int_detect || alu_of) begin
      b.mem_op = 2'd0; b.wd = 32'd0; b.ctrl_op = 2'd0; b.dst = 5'd0;
      b.we_ = 1'b1; b.out = 32'd0;
      b.exp = int_detect ? 3'd1 : 3'd3;
    end else begin
      b.mem_op = id_mem_op; b.wd = id_mem_wr_data; b.ctrl_op = id_ctrl_op;
      b.dst = id_dst_addr; b.we_ = id_gpr_we_; b.exp = id_exp_code; b.out = alu_out;
    end
    return b;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic bit model_ready(input int k);
    if (reset) return 1'b1;
    if (k == 0) return q0.size() < 2;
    return out_ready || (q1.size() == 0);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_ex_en", k), 128'(ex_en[k]), 128'(qsize(k) > 0));
      chk($sformatf("d%0d_in_ready", k), 128'(in_ready[k]), 128'(model_ready(k)));
      if (qsize(k) > 0)
        chk($sformatf("d%0d_beat", k), 128'(obs(k)), 128'((k == 0) ? q0[0] : q1[0]));
    end
  endtask

  task automatic model_update();
    bit    r0, r1;
    beat_t b;
    r0 = model_ready(0);
    r1 = model_ready(1);
    b  = fmt_model();
    for (int k = 0; k < 2; k++) begin
      if (in_valid && in_ready[k]) acc_obs[k]++;
      if (ex_en[k] && out_ready)   xfer_obs[k]++;
    end
    if (reset || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() > 0 && out_ready) void'(q0.pop_front());
      if (in_valid && r0) q0.push_back(b);
      if (q1.size() > 0 && out_ready) void'(q1.pop_front());
      if (in_valid && r1) q1.push_back(b);
    end
  endtask

  // Inputs are set at posedge+1; sample at posedge+4, then advance one cycle.
  task automatic step();
    #3;
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    alu_out        = $urandom;
    id_pc          = 30'($urandom);
    id_br_flag     = 1'($urandom);
    id_mem_op      = 2'($urandom);
    id_mem_wr_data = $urandom;
    id_ctrl_op     = 2'($urandom);
    id_dst_addr    = 5'($urandom);
    id_gpr_we_     = 1'($urandom);
    id_exp_code    = 3'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_d%0d_ex_en", tag, k), 128'(ex_en[k]), 128'(1'b0));
      chk($sformatf("%s_d%0d_in_ready", tag, k), 128'(in_ready[k]), 128'(1'b1));
      chk($sformatf("%s_d%0d_fields", tag, k), 128'(obs(k)), 128'(rst_beat()));
    end
  endtask

  initial begin
    acc_obs  = '{0, 0};
    xfer_obs = '{0, 0};
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; int_detect = 1'b0; alu_of = 1'b0;
    out_ready = 1'b0;
    alu_out = '0; id_pc = '0; id_br_flag = 1'b0; id_mem_op = '0; id_mem_wr_data = '0;
    id_ctrl_op = '0; id_dst_addr = '0; id_gpr_we_ = 1'b1; id_exp_code = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Basic one-cycle latency.
    in_valid = 1'b1; id_pc = 30'h10; alu_out = 32'h5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_ex_en", 128'(ex_en[0]), 128'(1'b1));
    chk("lat_ex_pc", 128'(ex_pc[0]), 128'(30'h10));
    chk("lat_ex_out", 128'(ex_out[0]), 128'(32'h5));
    step();

    // Stall: three beats offered, skid takes two.
    out_ready = 1'b0;
    acc_obs[0] = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; rand_fields();
      step();
      if (i == 1) chk("stall_in_ready_c2", 128'(in_ready[0]), 128'(1'b0));
    end
    chk("stall_accepted", 128'(acc_obs[0]), 128'(2));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    // Interrupt and overflow together: interrupt wins.
    in_valid = 1'b1; int_detect = 1'b1; alu_of = 1'b1; id_gpr_we_ = 1'b0;
    id_dst_addr = 5'd7; id_pc = 30'h123; id_mem_op = 2'd2; alu_out = 32'hdead;
    step();
    in_valid = 1'b0; int_detect = 1'b0; alu_of = 1'b0;
    chk("int_exp", 128'(ex_exp_code[0]), 128'(3'd1));
    chk("int_we", 128'(ex_gpr_we_[0]), 128'(1'b1));
    chk("int_dst", 128'(ex_dst_addr[0]), 128'(5'd0));
    chk("int_pc", 128'(ex_pc[0]), 128'(30'h123));
    step();

    // Flush while the skid entry is occupied.
    out_ready = 1'b0;
    repeat (2) begin in_valid = 1'b1; rand_fields(); step(); end
    chk("pre_flush_in_ready", 128'(in_ready[0]), 128'(1'b0));
    flush = 1'b1; rand_fields();
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_reset_outputs("flush");

    // Single-register mode with out_ready toggling each cycle.
    acc_obs[1] = 0; xfer_obs[1] = 0;
    for (int i = 0; i < 40 && acc_obs[1] < 8; i++) begin
      in_valid = 1'b1; out_ready = i[0]; rand_fields();
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("toggle_accepted", 128'(acc_obs[1]), 128'(8));
    chk("toggle_delivered", 128'(xfer_obs[1]), 128'(8));

    // Reset between clock edges.
    out_ready = 1'b0;
    repeat (2) begin in_valid = 1'b1; rand_fields(); step(); end
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    q0.delete(); q1.delete();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 3) != 0;
      int_detect = ($urandom % 10) == 0;
      alu_of     = ($urandom % 10) == 0;
      flush      = ($urandom % 40) == 0;
      rand_fields();
      step();
    end
    in_valid = 1'b0; flush = 1'b0; int_detect = 1'b0; alu_of = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("final_empty_d0", 128'(ex_en[0]), 128'(1'b0));
    chk("final_empty_d1", 128'(ex_en[1]), 128'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
